config_sram_array: RTL and testbench
====================================

# config_sram_array

Parametrised configuration memory for the FPGA fabric: NUM_FRAMES frames of FRAME_WIDTH SRAM bits. It is loaded serially from the configuration port and read back serially. Every stored bit drives both a true and a complemented output, as each SRAM cell does, so routing muxes and LUT inputs can connect directly. It sits between the configuration controller and the tile fabric, replacing hand-instantiated single-bit cells.

## Interface

- FRAME_WIDTH, 16: bits per frame; must be ≥ 2.
- NUM_FRAMES, 8: frames in the array; must be ≥ 1.
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse that begins an operation; sampled only in IDLE or DONE.
- cfg_mode  in  1  sampled with cfg_start: 0 = write (load), 1 = readback.
- cfg_din  in  1  serial configuration bit, LSB of each frame first, frame 0 first.
- cfg_din_valid  in  1  cfg_din is valid this cycle.
- cfg_din_ready  out  1  block accepts cfg_din this cycle.
- cfg_dout  out  1  serial readback bit, same ordering as the load.
- cfg_dout_valid  out  1  cfg_dout is valid this cycle; no backpressure.
- cfg_busy  out  1  high in any state other than IDLE or DONE.
- cfg_done  out  1  high in DONE.
- cfg_bits  out  NUM_FRAMES*FRAME_WIDTH  stored bits; frame f, bit b is at index f*FRAME_WIDTH+b.
- cfg_bits_n  out  NUM_FRAMES*FRAME_WIDTH  bitwise complement of cfg_bits, registered in the same cycle.

## Operation

- States: IDLE, LOAD, COMMIT, RB_FETCH, RB_SHIFT, DONE.
- Internal state:
  - frame_addr: $clog2(NUM_FRAMES) bits, minimum 1.
  - bit_cnt: $clog2(FRAME_WIDTH+1) bits.
  - frame_sr: FRAME_WIDTH bits.
- IDLE/DONE + cfg_start, cfg_mode=0: go to LOAD; frame_addr=0, bit_cnt=0.
- IDLE/DONE + cfg_start, cfg_mode=1: go to RB_FETCH; frame_addr=0.
- DONE is left only by cfg_start. cfg_start in any other state is ignored.
- LOAD:
  - cfg_din_ready=1.
  - On valid&ready: frame_sr <= {cfg_din, frame_sr[W-1:1]} and bit_cnt++.
  - When the FRAME_WIDTH-th bit is accepted, go to COMMIT.
- COMMIT (one cycle, cfg_din_ready=0):
  - mem[frame_addr] <= frame_sr; bit_cnt <= 0.
  - If frame_addr==NUM_FRAMES-1, go to DONE. Otherwise frame_addr++ and go to LOAD.
- RB_FETCH (one cycle): frame_sr <= mem[frame_addr]; bit_cnt <= 0; go to RB_SHIFT.
- RB_SHIFT:
  - cfg_dout=frame_sr[0] and cfg_dout_valid=1 every cycle; frame_sr shifts right.
  - After FRAME_WIDTH bits: if frame_addr==NUM_FRAMES-1 go to DONE, otherwise frame_addr++ and go to RB_FETCH.
- Readback never modifies mem.
- cfg_bits reflects mem continuously. A partial load leaves frames that are not yet committed at their previous values.
- cfg_din_valid outside LOAD is ignored. Gaps in cfg_din_valid during LOAD stall the load without loss of data.

## Timing

- Reset (asynchronous) clears state to IDLE:
  - mem, frame_sr, frame_addr and bit_cnt are all 0.
  - cfg_bits=0 and cfg_bits_n all ones.
  - cfg_din_ready, cfg_dout, cfg_dout_valid, cfg_busy and cfg_done are all 0.
- Reset mid-load or mid-readback aborts the operation and also clears every frame already committed.
- cfg_start at edge 0 gives cfg_busy=1 and the first LOAD or RB_FETCH cycle after edge 0.
- Minimum full load: NUM_FRAMES*(FRAME_WIDTH+1) cycles from the first LOAD cycle to DONE.
- A committed frame appears on cfg_bits/cfg_bits_n the cycle after COMMIT.
- Readback:
  - First cfg_dout_valid comes 2 cycles after the cfg_start edge.
  - One cycle gap between frames (RB_FETCH).
  - Total NUM_FRAMES*(FRAME_WIDTH+1) cycles.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.
- cfg_bits_n always equals ~cfg_bits on every cycle, including during reset.

## Test plan

(FRAME_WIDTH=4, NUM_FRAMES=2 unless stated.)

- Reset release: check all outputs at their reset values, with cfg_bits_n=8'hFF.
- Back-to-back load of bits 1,0,1,1 then 0,1,1,0: after the first COMMIT, cfg_bits=8'h0D. After the second, cfg_bits=8'h6D and cfg_bits_n=8'h92. cfg_done=1 at cycle 11 after the start edge.
- Load with cfg_din_valid toggling every other cycle: gives the same final 8'h6D. cfg_din_ready drops only in COMMIT.
- Readback after that load: cfg_dout sequence is 1,0,1,1,(gap),0,1,1,0 with cfg_dout_valid high exactly 8 cycles, and cfg_bits stays 8'h6D.
- Reset asserted after 6 accepted bits: state returns to IDLE and cfg_bits=0. A fresh load then succeeds.
- cfg_start pulsed mid-LOAD: ignored, and the load completes normally. Repeat the full load with FRAME_WIDTH=16, NUM_FRAMES=8 and random data; readback must match bit-for-bit.

Source files
------------

// File: rtl/config_sram_array_if.sv
// Serial configuration port of the configuration SRAM array: start/mode control,
// the load stream with its ready/valid handshake, the readback stream and status.
interface config_sram_array_if;
  logic cfg_start;
  logic cfg_mode;
  logic cfg_din;
  logic cfg_din_valid;
  logic cfg_din_ready;
  logic cfg_dout;
  logic cfg_dout_valid;
  logic cfg_busy;
  logic cfg_done;

  modport master (
    output cfg_start, cfg_mode, cfg_din, cfg_din_valid,
    input  cfg_din_ready, cfg_dout, cfg_dout_valid, cfg_busy, cfg_done
  );

  modport slave (
    input  cfg_start, cfg_mode, cfg_din, cfg_din_valid,
    output cfg_din_ready, cfg_dout, cfg_dout_valid, cfg_busy, cfg_done
  );
endinterface

// File: rtl/config_sram_array.sv
// Configuration memory of NUM_FRAMES x FRAME_WIDTH SRAM bits, loaded and read back
// serially frame by frame; every stored bit drives a true and a complemented output.
module config_sram_array #(
  parameter int FRAME_WIDTH = 16,
  parameter int NUM_FRAMES  = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  config_sram_array_if.slave                cfg,
  output logic [NUM_FRAMES*FRAME_WIDTH-1:0] cfg_bits,
  output logic [NUM_FRAMES*FRAME_WIDTH-1:0] cfg_bits_n
);

  localparam int AW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int CW = $clog2(FRAME_WIDTH + 1);

  localparam logic [AW-1:0] LAST_FRAME = AW'(NUM_FRAMES - 1);
  localparam logic [CW-1:0] LAST_BIT   = CW'(FRAME_WIDTH - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_COMMIT   = 3'd2;
  localparam logic [2:0] S_RB_FETCH = 3'd3;
  localparam logic [2:0] S_RB_SHIFT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  logic [2:0]             state_q, state_d;
  logic [AW-1:0]          frame_addr_q, frame_addr_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [FRAME_WIDTH-1:0] frame_sr_q, frame_sr_d;
  logic                   commit_en;
  logic [FRAME_WIDTH-1:0] rd_frame;

  // True and complement planes are both stored so that each cell drives its two
  // outputs straight from flops, exactly like a 6T cell's Q/QB pair.
  logic [FRAME_WIDTH-1:0] mem_q   [NUM_FRAMES];
  logic [FRAME_WIDTH-1:0] mem_n_q [NUM_FRAMES];

  always_comb begin
    rd_frame = '0;
    for (int f = 0; f < NUM_FRAMES; f++) begin
      if (frame_addr_q == AW'(f)) rd_frame = mem_q[f];
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves a
    // value held over from the previous evaluation and no latch is inferred.
    state_d      = state_q;
    frame_addr_d = frame_addr_q;
    bit_cnt_d    = bit_cnt_q;
    frame_sr_d   = frame_sr_q;
    commit_en    = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (cfg.cfg_start) begin
          frame_addr_d = '0;
          bit_cnt_d    = '0;
          state_d      = cfg.cfg_mode ? S_RB_FETCH : S_LOAD;
        end
      end

      S_LOAD: begin
        // Valid gaps simply hold everything, so a stalled stream loses nothing.
        if (cfg.cfg_din_valid) begin
          frame_sr_d = {cfg.cfg_din, frame_sr_q[FRAME_WIDTH-1:1]};
          bit_cnt_d  = bit_cnt_q + CW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = S_COMMIT;
        end
      end

      S_COMMIT: begin
        commit_en = 1'b1;
        bit_cnt_d = '0;
        if (frame_addr_q == LAST_FRAME) begin
          state_d = S_DONE;
        end else begin
          frame_addr_d = frame_addr_q + AW'(1);
          state_d      = S_LOAD;
        end
      end

      S_RB_FETCH: begin
        frame_sr_d = rd_frame;
        bit_cnt_d  = '0;
        state_d    = S_RB_SHIFT;
      end

      S_RB_SHIFT: begin
        frame_sr_d = {1'b0, frame_sr_q[FRAME_WIDTH-1:1]};
        bit_cnt_d  = bit_cnt_q + CW'(1);
        if (bit_cnt_q == LAST_BIT) begin
          if (frame_addr_q == LAST_FRAME) begin
            state_d = S_DONE;
          end else begin
            frame_addr_d = frame_addr_q + AW'(1);
            state_d      = S_RB_FETCH;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments only, so every
  // flop samples the pre-edge value of the others regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      frame_addr_q <= '0;
      bit_cnt_q    <= '0;
      frame_sr_q   <= '0;
    end else begin
      state_q      <= state_d;
      frame_addr_q <= frame_addr_d;
      bit_cnt_q    <= bit_cnt_d;
      frame_sr_q   <= frame_sr_d;
    end
  end

  // NOTE: the storage is flops with an asynchronous clear, not a RAM macro; a reset
  // must leave the fabric in a known, unconfigured state, so clearing it is required.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < NUM_FRAMES; f++) begin
        mem_q[f]   <= '0;
        mem_n_q[f] <= '1;
      end
    end else if (commit_en) begin
      for (int f = 0; f < NUM_FRAMES; f++) begin
        if (frame_addr_q == AW'(f)) begin
          mem_q[f]   <= frame_sr_q;
          mem_n_q[f] <= ~frame_sr_q;
        end
      end
    end
  end

  for (genvar f = 0; f < NUM_FRAMES; f++) begin : g_frame_out
    assign cfg_bits[f*FRAME_WIDTH +: FRAME_WIDTH]   = mem_q[f];
    assign cfg_bits_n[f*FRAME_WIDTH +: FRAME_WIDTH] = mem_n_q[f];
  end

  // Port outputs are decoded from registered state only.
  assign cfg.cfg_din_ready  = (state_q == S_LOAD);
  assign cfg.cfg_dout_valid = (state_q == S_RB_SHIFT);
  assign cfg.cfg_dout       = (state_q == S_RB_SHIFT) & frame_sr_q[0];
  assign cfg.cfg_done       = (state_q == S_DONE);
  assign cfg.cfg_busy       = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_config_sram_array.sv
// Self-checking bench for config_sram_array: a 4x2 and a 16x8 instance driven with
// directed and random loads/readbacks, checked against a frame-level reference model.
module tb_config_sram_array;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_s;
  logic rst_b;

  config_sram_array_if s_if ();
  config_sram_array_if b_if ();

  logic [7:0]   s_bits,   s_bits_n;
  logic [127:0] b_bits,   b_bits_n;

  config_sram_array #(.FRAME_WIDTH(4), .NUM_FRAMES(2)) u_small (
    .clk        (clk),
    .reset      (rst_s),
    .cfg        (s_if),
    .cfg_bits   (s_bits),
    .cfg_bits_n (s_bits_n)
  );

  config_sram_array #(.FRAME_WIDTH(16), .NUM_FRAMES(8)) u_big (
    .clk        (clk),
    .reset      (rst_b),
    .cfg        (b_if),
    .cfg_bits   (b_bits),
    .cfg_bits_n (b_bits_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the committed contents of each frame, per instance.
  logic [15:0] mdl [2][8];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fw(input bit big);
    return big ? 16 : 4;
  endfunction

  function automatic int nf(input bit big);
    return big ? 8 : 2;
  endfunction

  function automatic logic [127:0] exp_bits(input bit big);
    logic [127:0] r = '0;
    for (int f = 0; f < nf(big); f++)
      for (int b = 0; b < fw(big); b++) r[f*fw(big)+b] = mdl[big][f][b];
    return r;
  endfunction

  function automatic logic [127:0] exp_bits_n(input bit big);
    logic [127:0] r = '0;
    for (int f = 0; f < nf(big); f++)
      for (int b = 0; b < fw(big); b++) r[f*fw(big)+b] = ~mdl[big][f][b];
    return r;
  endfunction

  function automatic logic [127:0] obs_bits(input bit big);
    return big ? b_bits : {120'd0, s_bits};
  endfunction

  function automatic logic [127:0] obs_bits_n(input bit big);
    return big ? b_bits_n : {120'd0, s_bits_n};
  endfunction

  function automatic logic obs_ready(input bit big);
    return big ? b_if.cfg_din_ready : s_if.cfg_din_ready;
  endfunction

  function automatic logic obs_dout(input bit big);
    return big ? b_if.cfg_dout : s_if.cfg_dout;
  endfunction

  function automatic logic obs_dv(input bit big);
    return big ? b_if.cfg_dout_valid : s_if.cfg_dout_valid;
  endfunction

  function automatic logic obs_busy(input bit big);
    return big ? b_if.cfg_busy : s_if.cfg_busy;
  endfunction

  function automatic logic obs_done(input bit big);
    return big ? b_if.cfg_done : s_if.cfg_done;
  endfunction

  task automatic drive(input bit big, input logic st, input logic md, input logic di, input logic dv);
    if (big) begin
      b_if.cfg_start = st; b_if.cfg_mode = md; b_if.cfg_din = di; b_if.cfg_din_valid = dv;
    end else begin
      s_if.cfg_start = st; s_if.cfg_mode = md; s_if.cfg_din = di; s_if.cfg_din_valid = dv;
    end
  endtask

  task automatic model_reset(input bit big);
    for (int f = 0; f < 8; f++) mdl[big][f] = '0;
  endtask

  task automatic check_reset(input bit big, input string tag);
    check({tag, "_bits"},   obs_bits(big),   exp_bits(big));
    check({tag, "_bits_n"}, obs_bits_n(big), exp_bits_n(big));
    check({tag, "_ready"},  128'(obs_ready(big)), 128'(0));
    check({tag, "_dout"},   128'(obs_dout(big)),  128'(0));
    check({tag, "_dv"},     128'(obs_dv(big)),    128'(0));
    check({tag, "_busy"},   128'(obs_busy(big)),  128'(0));
    check({tag, "_done"},   128'(obs_done(big)),  128'(0));
  endtask

  // gap: 0 = valid every cycle, 1 = valid every other cycle, 2 = random valid.
  // glitch_at: cycle index of a stray cfg_start (mode=1) pulse, -1 for none.
  // abort_after: stop driving once this many bits were accepted, -1 for a full load.
  task automatic run_load(input bit big, input logic [15:0] fr [8], input int gap,
                          input int glitch_at, input int abort_after, input string tag);
    int  w = fw(big);
    int  n = nf(big);
    int  limit = 4 * n * (w + 1) + 8;
    int  f = 0, b = 0, cyc = 0, taken = 0;
    bit  commit_pending = 1'b0;
    logic dv;
    drive(big, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    check({tag, "_busy_start"}, 128'(obs_busy(big)), 128'(1));
    while (f < n && cyc <= limit) begin
      check({tag, "_ready"}, 128'(obs_ready(big)), 128'(!commit_pending));
      if (taken == abort_after) begin
        drive(big, 1'b0, 1'b0, 1'b0, 1'b0);
        return;
      end
      if (gap == 0)      dv = 1'b1;
      else if (gap == 1) dv = (cyc % 2 == 0);
      else               dv = 1'($urandom_range(0, 1));
      drive(big, cyc == glitch_at, cyc == glitch_at, fr[f][b], dv);
      tick();
      cyc++;
      if (commit_pending) begin
        mdl[big][f] = fr[f];
        f++;
        commit_pending = 1'b0;
        check({tag, "_bits"},   obs_bits(big),   exp_bits(big));
        check({tag, "_bits_n"}, obs_bits_n(big), exp_bits_n(big));
      end else if (dv) begin
        taken++;
        b++;
        if (b == w) begin
          b = 0;
          commit_pending = 1'b1;
        end
      end
    end
    drive(big, 1'b0, 1'b0, 1'b0, 1'b0);
    check({tag, "_finished"}, 128'(f), 128'(n));
    check({tag, "_done"}, 128'(obs_done(big)), 128'(1));
    check({tag, "_busy_end"}, 128'(obs_busy(big)), 128'(0));
    if (gap == 0) check({tag, "_cycles"}, 128'(cyc), 128'(n * (w + 1)));
  endtask

  task automatic run_readback(input bit big, input string tag);
    int w = fw(big);
    int n = nf(big);
    int total = n * (w + 1);
    int seen = 0;
    bit ev;
    drive(big, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    drive(big, 1'b0, 1'b0, 1'b0, 1'b0);
    // Cycle k after the start edge: k multiple of (w+1) is a fetch gap, else bit k%(w+1)-1
    // of frame k/(w+1) is on the output.
    for (int k = 0; k < total; k++) begin
      ev = (k % (w + 1)) != 0;
      check({tag, "_dv"},   128'(obs_dv(big)),   128'(ev));
      check({tag, "_busy"}, 128'(obs_busy(big)), 128'(1));
      if (ev) check({tag, "_dout"}, 128'(obs_dout(big)), 128'(mdl[big][k / (w + 1)][k % (w + 1) - 1]));
      if (obs_dv(big)) seen++;
      tick();
    end
    check({tag, "_nvalid"}, 128'(seen), 128'(n * w));
    check({tag, "_done"},   128'(obs_done(big)), 128'(1));
    check({tag, "_dv_end"}, 128'(obs_dv(big)),   128'(0));
    check({tag, "_bits"},   obs_bits(big),   exp_bits(big));
    check({tag, "_bits_n"}, obs_bits_n(big), exp_bits_n(big));
  endtask

  initial begin
    logic [15:0] fr_a [8];
    logic [15:0] fr_b [8];
    logic [15:0] fr_r [8];

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_s = 1'b1;
    rst_b = 1'b1;
    model_reset(1'b0);
    model_reset(1'b1);
    tick();
    check("in_reset_bits_n_small", obs_bits_n(1'b0), 128'hFF);
    check_reset(1'b1, "in_reset_big");
    tick();
    rst_s = 1'b0;
    rst_b = 1'b0;
    tick();
    check_reset(1'b0, "rst_small");
    check_reset(1'b1, "rst_big");

    // Frames loaded LSB first: 1,0,1,1 -> 4'hD and 0,1,1,0 -> 4'h6.
    fr_a = '{16'hD, 16'h6, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_load(1'b0, fr_a, 0, -1, -1, "b2b");
    check("b2b_final",   obs_bits(1'b0),   128'h6D);
    check("b2b_final_n", obs_bits_n(1'b0), 128'h92);

    run_readback(1'b0, "rb");
    check("rb_unchanged", obs_bits(1'b0), 128'h6D);

    // Abort after 6 accepted bits: frame 0 is committed, frame 1 is half loaded.
    fr_b = '{16'h3, 16'hA, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    run_load(1'b0, fr_b, 0, -1, 6, "part");
    check("part_bits", obs_bits(1'b0), 128'h63);
    rst_s = 1'b1;
    model_reset(1'b0);
    #1;
    check_reset(1'b0, "abort_async");
    tick();
    rst_s = 1'b0;
    tick();
    check_reset(1'b0, "abort");

    run_load(1'b0, fr_a, 1, -1, -1, "gap");
    check("gap_final", obs_bits(1'b0), 128'h6D);

    run_load(1'b0, fr_b, 0, 2, -1, "glitch");
    check("glitch_final", obs_bits(1'b0), 128'hA3);
    run_readback(1'b0, "rb_glitch");

    for (int f = 0; f < 8; f++) fr_r[f] = 16'($urandom);
    run_load(1'b1, fr_r, 0, 7, -1, "big");
    run_readback(1'b1, "big_rb");

    for (int f = 0; f < 8; f++) fr_r[f] = 16'($urandom);
    run_load(1'b1, fr_r, 2, 30, -1, "big_rnd");
    run_readback(1'b1, "big_rnd_rb");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
